// File: rtl/cache_control_if.sv
// CPU-side and physical-memory-side signals of the L1 cache controller, with the
// controller as the slave and the CPU adapter / line adaptor pair as the master.
interface cache_control_if;
  // Requests (mem_read/mem_write, pmem_read/pmem_write) act as valid and are held
  // until the matching one-cycle ready pulse (mem_resp / pmem_resp) is sampled high.
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_byte_enable256;
  logic        mem_resp;
  logic [31:0] data_write_en;
  logic [2:0]  data_rindex;
  logic [2:0]  data_windex;
  logic        data_sel_mem;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic        pmem_resp;

  modport master (
    output mem_read, mem_write, mem_address, mem_byte_enable256, pmem_resp,
    input  mem_resp, data_write_en, data_rindex, data_windex, data_sel_mem,
           pmem_read, pmem_write, pmem_address
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_byte_enable256, pmem_resp,
    output mem_resp, data_write_en, data_rindex, data_windex, data_sel_mem,
           pmem_read, pmem_write, pmem_address
  );
endinterface

// File: rtl/cache_control.sv
// Direct-mapped write-back/write-allocate L1 controller: 8 lines x 32 bytes.
// Holds tag/valid/dirty, decides hit/miss, sequences writeback and line fill.
module cache_control (
  input  logic           clk,
  input  logic           rst_n,
  cache_control_if.slave bus,
  output logic [1:0]     dbg_state
);
  localparam int S_OFFSET = 5;
  localparam int S_INDEX  = 3;
  localparam int S_TAG    = 32 - S_OFFSET - S_INDEX;
  localparam int S_MASK   = 2 ** S_OFFSET;
  localparam int NUM_SETS = 2 ** S_INDEX;

  typedef enum logic [1:0] {IDLE = 2'd0, WRITEBACK = 2'd1, ALLOCATE = 2'd2} state_t;

  state_t               state, state_next;
  logic [S_TAG-1:0]     tag_q [NUM_SETS];
  logic [NUM_SETS-1:0]  valid_q, dirty_q;
  logic [S_TAG-1:0]     miss_tag;
  logic [S_INDEX-1:0]   miss_index;

  logic [S_TAG-1:0]     req_tag;
  logic [S_INDEX-1:0]   req_index;
  logic                 req, hit;
  logic                 set_dirty, clr_dirty, fill, latch_miss;
  logic                 unused_addr_bits;

  logic                 mem_resp_c, sel_mem_c, pmem_read_c, pmem_write_c;
  logic [S_MASK-1:0]    wen_c;
  logic [S_INDEX-1:0]   rindex_c, windex_c;
  logic [31:0]          pmem_addr_c;

  assign req_tag          = bus.mem_address[31:8];
  assign req_index        = bus.mem_address[7:5];
  assign unused_addr_bits = ^bus.mem_address[4:0];
  assign req              = bus.mem_read | bus.mem_write;
  assign hit              = req && valid_q[req_index] && (tag_q[req_index] == req_tag);

  always_comb begin
    state_next   = state;
    mem_resp_c   = 1'b0;
    wen_c        = '0;
    rindex_c     = req_index;
    windex_c     = req_index;
    sel_mem_c    = 1'b0;
    pmem_read_c  = 1'b0;
    pmem_write_c = 1'b0;
    pmem_addr_c  = '0;
    set_dirty    = 1'b0;
    clr_dirty    = 1'b0;
    fill         = 1'b0;
    latch_miss   = 1'b0;
    case (state)
      IDLE: begin
        if (hit) begin
          mem_resp_c = 1'b1;
          // Write wins when both strobes are up; an all-zero mask still dirties the line.
          if (bus.mem_write) begin
            wen_c     = bus.mem_byte_enable256;
            set_dirty = 1'b1;
          end
        end else if (req) begin
          latch_miss = 1'b1;
          state_next = (valid_q[req_index] && dirty_q[req_index]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        pmem_write_c = 1'b1;
        pmem_addr_c  = {tag_q[miss_index], miss_index, 5'b0};
        rindex_c     = miss_index;
        if (bus.pmem_resp) begin
          clr_dirty  = 1'b1;
          state_next = ALLOCATE;
        end
      end
      ALLOCATE: begin
        pmem_read_c = 1'b1;
        pmem_addr_c = {miss_tag, miss_index, 5'b0};
        if (bus.pmem_resp) begin
          wen_c      = '1;
          windex_c   = miss_index;
          sel_mem_c  = 1'b1;
          fill       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      miss_tag   <= '0;
      miss_index <= '0;
    end else begin
      state <= state_next;
      if (latch_miss) begin
        miss_tag   <= req_tag;
        miss_index <= req_index;
      end
      if (set_dirty) dirty_q[req_index]  <= 1'b1;
      if (clr_dirty) dirty_q[miss_index] <= 1'b0;
      if (fill) begin
        valid_q[miss_index] <= 1'b1;
        dirty_q[miss_index] <= 1'b0;
      end
    end
  end

  // Tags need no reset: a line's tag is only consulted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (fill) tag_q[miss_index] <= miss_tag;
  end

  assign bus.mem_resp      = mem_resp_c;
  assign bus.data_write_en = wen_c;
  assign bus.data_rindex   = rindex_c;
  assign bus.data_windex   = windex_c;
  assign bus.data_sel_mem  = sel_mem_c;
  assign bus.pmem_read     = pmem_read_c;
  assign bus.pmem_write    = pmem_write_c;
  assign bus.pmem_address  = pmem_addr_c;
  assign dbg_state         = state;
endmodule

// File: tb/tb_cache_control.sv
// Bench for cache_control: reference tag/valid/dirty model predicts pmem transfers
// into an expected queue; a pmem responder pops and compares each transfer.
module tb_cache_control;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         total = 0;
  int         bad = 0;

  logic [32:0] exp_q[$];
  logic [23:0] m_tag [8];
  logic [7:0]  m_valid, m_dirty;

  logic        hold_resp;
  logic        in_xfer;
  logic        last_is_write;
  logic [2:0]  xfer_idx;
  int          wait_cnt;

  cache_control_if bus();

  cache_control dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Physical memory model: random latency, one-cycle pmem_resp, transfer checks.
  initial begin
    logic [32:0] exp;
    bus.pmem_resp = 1'b0;
    in_xfer   = 1'b0;
    hold_resp = 1'b0;
    last_is_write = 1'b0;
    xfer_idx  = '0;
    wait_cnt  = 0;
    forever begin
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      if (!rst_n) begin
        in_xfer = 1'b0;
        continue;
      end
      if (bus.pmem_read || bus.pmem_write)
        chk("pmem_excl", {63'd0, bus.pmem_read & bus.pmem_write}, 64'd0);
      if (in_xfer) begin
        chk("pmem_hold", {62'd0, bus.pmem_write, bus.pmem_read},
            {62'd0, last_is_write, !last_is_write});
      end else if (bus.pmem_read || bus.pmem_write) begin
        in_xfer       = 1'b1;
        last_is_write = bus.pmem_write;
        xfer_idx      = bus.pmem_address[7:5];
        wait_cnt      = $urandom_range(0, 3);
        chk("pmem_expected", {63'd0, exp_q.size() > 0}, 64'd1);
        if (exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          chk("pmem_xfer", {31'd0, bus.pmem_write, bus.pmem_address}, {31'd0, exp});
        end
      end
      if (in_xfer && !hold_resp) begin
        if (wait_cnt == 0) begin
          bus.pmem_resp = 1'b1;
          in_xfer = 1'b0;
          #1;
          if (last_is_write) begin
            chk("wb_rindex", {61'd0, bus.data_rindex}, {61'd0, xfer_idx});
          end else begin
            chk("fill_wen", {32'd0, bus.data_write_en}, 64'hFFFF_FFFF);
            chk("fill_sel", {63'd0, bus.data_sel_mem}, 64'd1);
            chk("fill_windex", {61'd0, bus.data_windex}, {61'd0, xfer_idx});
          end
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // One CPU request: predict pmem traffic, wait for mem_resp, check the response cycle.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] mask);
    logic [2:0]  idx;
    logic [23:0] tg;
    logic        hit;
    logic        done;
    int          cyc;
    int          fill_cyc;
    idx = addr[7:5];
    tg  = addr[31:8];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    if (!hit) begin
      if (m_valid[idx] && m_dirty[idx]) exp_q.push_back({1'b1, m_tag[idx], idx, 5'b0});
      exp_q.push_back({1'b0, tg, idx, 5'b0});
    end
    bus.mem_read           = rd;
    bus.mem_write          = wr;
    bus.mem_address        = addr;
    bus.mem_byte_enable256 = mask;
    cyc      = 0;
    fill_cyc = -10;
    done     = 1'b0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      #2;
      if (bus.pmem_resp && bus.pmem_read) fill_cyc = cyc;
      if (bus.mem_resp) begin
        done = 1'b1;
        if (hit) chk("hit_latency", 64'(cyc), 64'd0);
        else     chk("miss_latency", 64'(cyc), 64'(fill_cyc + 1));
        chk("resp_wen", {32'd0, bus.data_write_en}, wr ? {32'd0, mask} : 64'd0);
        chk("resp_rindex", {61'd0, bus.data_rindex}, {61'd0, idx});
        if (wr) begin
          chk("resp_sel", {63'd0, bus.data_sel_mem}, 64'd0);
          chk("resp_windex", {61'd0, bus.data_windex}, {61'd0, idx});
        end
        chk("resp_pmem_idle", {62'd0, bus.pmem_read, bus.pmem_write}, 64'd0);
        chk("resp_q_empty", 64'(exp_q.size()), 64'd0);
      end
      cyc++;
    end
    chk("resp_seen", {63'd0, done}, 64'd1);
    @(posedge clk);
    #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    m_tag[idx]   = tg;
    m_valid[idx] = 1'b1;
    if (!hit) m_dirty[idx] = 1'b0;
    if (wr)   m_dirty[idx] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          op;
    logic        seen;
    int          cyc;

    // Reset with a request already asserted.
    rst_n = 1'b0;
    bus.mem_read = 1'b1;
    bus.mem_write = 1'b0;
    bus.mem_address = 32'h0000_0040;
    bus.mem_byte_enable256 = '0;
    m_valid = '0;
    m_dirty = '0;
    repeat (2) @(negedge clk);
    chk("rst_state", {62'd0, dbg_state}, 64'd0);
    chk("rst_mem_resp", {63'd0, bus.mem_resp}, 64'd0);
    chk("rst_pmem", {62'd0, bus.pmem_read, bus.pmem_write}, 64'd0);
    chk("rst_wen", {32'd0, bus.data_write_en}, 64'd0);
    bus.mem_read = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_req(1'b1, 1'b0, 32'h0000_0040, 32'h0);            // clean miss, fill line 2
    do_req(1'b1, 1'b0, 32'h0000_0040, 32'h0);            // read hit
    do_req(1'b0, 1'b1, 32'h0000_0044, 32'h0000_00F0);    // write hit, dirty line 2
    do_req(1'b1, 1'b0, 32'h0001_0040, 32'h0);            // dirty eviction
    do_req(1'b1, 1'b0, 32'h0000_0040, 32'h0);            // clean miss, no writeback
    do_req(1'b1, 1'b1, 32'h0000_0040, 32'h0000_0F00);    // both strobes: write

    // Spurious pmem_resp in IDLE must not move the FSM.
    @(negedge clk);
    #1;
    bus.pmem_resp = 1'b1;
    @(negedge clk);
    #2;
    chk("spurious_state", {62'd0, dbg_state}, 64'd0);
    @(posedge clk);
    #1;
    do_req(1'b1, 1'b0, 32'h0000_0048, 32'h0);            // still a hit

    // Zero byte mask still dirties the line.
    do_req(1'b1, 1'b0, 32'h0000_0060, 32'h0);
    do_req(1'b0, 1'b1, 32'h0000_0060, 32'h0);
    do_req(1'b1, 1'b0, 32'h0002_0060, 32'h0);
    do_req(1'b0, 1'b1, 32'h0000_0080, 32'hA5A5_0000);    // write miss allocates

    for (int i = 0; i < 40; i++) begin
      a = {22'd0, 2'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
      op = $urandom_range(0, 2);
      do_req(op != 1, op != 0, a, $urandom);
    end

    // Reset in the middle of a writeback.
    do_req(1'b0, 1'b1, 32'h0000_00A0, 32'hFFFF_0000);
    if (!(m_valid[5] && m_dirty[5])) exp_q.delete();
    hold_resp = 1'b1;
    exp_q.push_back({1'b1, 24'h0, 3'd5, 5'b0});
    bus.mem_read    = 1'b1;
    bus.mem_address = 32'h0001_00A0;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      #2;
      seen = bus.pmem_write;
      cyc++;
    end
    chk("wb_started", {63'd0, seen}, 64'd1);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_pmem", {62'd0, bus.pmem_read, bus.pmem_write}, 64'd0);
    chk("arst_resp_wen", {31'd0, bus.mem_resp, bus.data_write_en}, 64'd0);
    chk("arst_state", {62'd0, dbg_state}, 64'd0);
    bus.mem_read = 1'b0;
    hold_resp = 1'b0;
    exp_q.delete();
    m_valid = '0;
    m_dirty = '0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_req(1'b1, 1'b0, 32'h0001_00A0, 32'h0);            // miss, no writeback
    do_req(1'b1, 1'b0, 32'h0000_0040, 32'h0);            // miss, no writeback

    repeat (3) @(negedge clk);
    chk("q_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
